instr_encode: RTL and testbench

Sequential MIPS instruction encoder: accepts decoded instruction fields (opcode, funct, rs, rt, rd, shamt, imm, addr) with a format select and packs them into 32-bit R/I/J words. It writes them one by one into instruction memory through an acknowledged write port at an auto-incrementing address. It is the write-side counterpart of the CPU's field decoder, used by the test loader and self-modifying-code paths to fill instruction memory. A 2-entry FIFO decouples field input from memory back-pressure.

---
 rtl/instr_encode.sv | 189 ++++++++++++++++++
 tb/tb_instr_encode.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode.sv
// instr_encode: packs decoded MIPS fields into 32-bit R/I/J words and writes
// them to instruction memory at an auto-incrementing word address.
// A 2-entry FIFO sits between field input and the acknowledged write port.
//
// Optional build macro: ENC_FIELD_CHECK_EN
//   defined   -> R bundles need opcode 0; a nonzero shamt is allowed only with
//                funct 0x00/0x02/0x03; J bundles need opcode 2 or 3.
//                Violating bundles are dropped and set err.
//   undefined -> only fmt=3 is illegal; all fields are packed verbatim.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, start_addr     load write pointer, flush FIFO, clear flags
//   in_valid, in_ready    field bundle handshake
//   fmt                   0=R, 1=I, 2=J, 3=reserved
//   opcode..addr          instruction fields
//   wr_en, wr_addr,
//   wr_data, wr_ack       memory write port, held until wr_ack
//   err                   sticky: illegal bundle dropped
//   wrap                  sticky: write pointer wrapped past all-ones
//   count                 words written since last start/reset (saturating)
module instr_encode #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ack,
    output logic              err,
    output logic              wrap,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state_q, state_n;
    logic [31:0]       mem0_q, mem0_n;   // FIFO head, drives wr_data
    logic [31:0]       mem1_q, mem1_n;
    logic [1:0]        occ_q, occ_n;
    logic [ADDR_W-1:0] ptr_q, ptr_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic              err_q, err_n;
    logic              wrap_q, wrap_n;
    logic              wr_en_q, wr_en_n;
    logic              rdy_q, rdy_n;

    logic [31:0]       enc_word;
    logic              legal;
    logic              accept, push, drop, pop;

    // Field packing and legality of the offered bundle
    always_comb begin
        enc_word = '0;
        legal    = 1'b1;
        unique case (fmt)
            2'd0:    enc_word = {opcode, rs, rt, rd, shamt, funct};
            2'd1:    enc_word = {opcode, rs, rt, imm};
            2'd2:    enc_word = {opcode, addr};
            default: legal    = 1'b0;
        endcase
`ifdef ENC_FIELD_CHECK_EN
        if (fmt == 2'd0) begin
            if (opcode != 6'd0)
                legal = 1'b0;
            if ((shamt != 5'd0) && !(funct inside {6'h00, 6'h02, 6'h03}))
                legal = 1'b0;
        end
        if ((fmt == 2'd2) && (opcode != 6'd2) && (opcode != 6'd3))
            legal = 1'b0;
`endif
    end

    // in_ready already excludes start, so accept never coincides with start
    assign accept = in_valid & in_ready;
    assign push   = accept & legal;
    assign drop   = accept & ~legal;
    assign pop    = (state_q == WRITE) & wr_ack & ~start;

    // Next-state: FIFO, write FSM, pointer and flags
    always_comb begin
        state_n = state_q;
        mem0_n  = mem0_q;
        mem1_n  = mem1_q;
        occ_n   = occ_q;
        ptr_n   = ptr_q;
        count_n = count_q;
        err_n   = err_q;
        wrap_n  = wrap_q;

        // Shift FIFO: pop moves entry 1 to the head, push fills the first free slot
        if (pop) begin
            mem0_n = mem1_q;
            occ_n  = occ_q - 2'd1;
        end
        if (push) begin
            if (occ_n == 2'd0)
                mem0_n = enc_word;
            else
                mem1_n = enc_word;
            occ_n = occ_n + 2'd1;
        end

        if (pop) begin
            ptr_n = ptr_q + ADDR_W'(1);
            if (ptr_q == '1)
                wrap_n = 1'b1;
            if (count_q != CNT_MAX)
                count_n = count_q + CNT_W'(1);
        end
        if (drop)
            err_n = 1'b1;

        unique case (state_q)
            IDLE:    if (occ_q != 2'd0) state_n = WRITE;
            WRITE:   if (pop && (occ_n == 2'd0)) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n = IDLE;
            occ_n   = 2'd0;
            ptr_n   = start_addr;
            count_n = '0;
            err_n   = 1'b0;
            wrap_n  = 1'b0;
        end

        wr_en_n = (state_n == WRITE);
        rdy_n   = (occ_n != 2'd2);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mem0_q  <= '0;
            mem1_q  <= '0;
            occ_q   <= 2'd0;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
            wr_en_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            mem0_q  <= mem0_n;
            mem1_q  <= mem1_n;
            occ_q   <= occ_n;
            ptr_q   <= ptr_n;
            count_q <= count_n;
            err_q   <= err_n;
            wrap_q  <= wrap_n;
            wr_en_q <= wr_en_n;
            rdy_q   <= rdy_n;
        end
    end

    // start masks in_ready in its own cycle so no bundle slips in during a flush
    assign in_ready = rdy_q & ~start;
    assign wr_en    = wr_en_q;
    assign wr_addr  = ptr_q;
    assign wr_data  = mem0_q;
    assign err      = err_q;
    assign wrap     = wrap_q;
    assign count    = count_q;

endmodule

// File: tb/tb_instr_encode.sv
// Bench for instr_encode: directed scenarios plus randomized traffic, checked
// against a transaction-level model (queue of pending words, expected pointer,
// flags and count).
module tb_instr_encode;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, shamt;
    logic [15:0]       imm;
    logic [25:0]       addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ack;
    logic              err, wrap;
    logic [ADDR_W:0]   count;

    always #5 clk = ~clk;

    instr_encode #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .imm(imm), .addr(addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .err(err), .wrap(wrap), .count(count)
    );

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] mq[$];
    logic [7:0]  mptr;
    bit          merr, mwrap, mwen;
    int          mcount;

    // Instruction word from the field weights of the MIPS formats
    function automatic logic [31:0] ref_word();
        logic [31:0] w;
        w = 32'(opcode) * 32'h0400_0000;
        case (fmt)
            2'd0: w = w + 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000
                        + 32'(rd) * 32'h800 + 32'(shamt) * 32'd64 + 32'(funct);
            2'd1: w = w + 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000 + 32'(imm);
            default: w = w + 32'(addr);
        endcase
        return w;
    endfunction

    function automatic bit ref_legal();
        if (fmt == 2'd3) return 1'b0;
`ifdef ENC_FIELD_CHECK_EN
        if (fmt == 2'd0 && opcode != 6'd0) return 1'b0;
        if (fmt == 2'd0 && shamt != 5'd0 && funct != 6'h00 && funct != 6'h02 && funct != 6'h03)
            return 1'b0;
        if (fmt == 2'd2 && opcode != 6'd2 && opcode != 6'd3) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Apply the current inputs to the model, clock once, then compare
    task automatic cyc();
        int pre;
        pre = mq.size();
        if (start) begin
            mq.delete();
            mptr   = start_addr;
            merr   = 1'b0;
            mwrap  = 1'b0;
            mcount = 0;
        end else begin
            if (mwen && wr_ack) begin
                void'(mq.pop_front());
                if (mptr == 8'hFF) mwrap = 1'b1;
                mptr = mptr + 8'd1;
                if (mcount < 256) mcount++;
            end
            if (in_valid && pre < 2) begin
                if (ref_legal()) mq.push_back(ref_word());
                else merr = 1'b1;
            end
        end
        mwen = (pre > 0) && (mq.size() > 0);
        @(posedge clk);
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'((mq.size() < 2) && !start));
        chk("wr_en", 32'(wr_en), 32'(mwen));
        if (mwen) begin
            chk("wr_addr", 32'(wr_addr), 32'(mptr));
            chk("wr_data", wr_data, mq[0]);
        end
        chk("err", 32'(err), 32'(merr));
        chk("wrap", 32'(wrap), 32'(mwrap));
        chk("count", 32'(count), 32'(mcount));
    endtask

    task automatic set_fields(input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                              input logic [4:0] sh, input logic [15:0] im, input logic [25:0] ad);
        fmt = f; opcode = op; funct = fn; rs = s; rt = t; rd = d; shamt = sh; imm = im; addr = ad;
    endtask

    task automatic rand_fields(input logic [1:0] f);
        set_fields(f, ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom),
                   ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom),
                   5'($urandom), 5'($urandom), 5'($urandom),
                   ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom),
                   16'($urandom), 26'($urandom));
    endtask

    task automatic do_start(input logic [7:0] sa);
        start = 1'b1; start_addr = sa; in_valid = 1'b0;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; start_addr = '0; in_valid = 1'b0; wr_ack = 1'b0;
        set_fields(2'd0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        mptr = '0; merr = 1'b0; mwrap = 1'b0; mwen = 1'b0; mcount = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        cyc();

        // R bundle: latency, packing and count
        do_start(8'h10);
        set_fields(2'd0, 6'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        in_valid = 1'b1; cyc(); in_valid = 1'b0;
        chk("t1_wr_en_early", 32'(wr_en), 32'd0);
        cyc();
        chk("t1_wr_en", 32'(wr_en), 32'd1);
        chk("t1_addr", 32'(wr_addr), 32'h10);
        chk("t1_data", wr_data, 32'h0022_1820);
        wr_ack = 1'b1; cyc(); wr_ack = 1'b0;
        chk("t1_count", 32'(count), 32'd1);

        // I then J with ack tied high: consecutive writes
        do_start(8'h10);
        wr_ack = 1'b1;
        set_fields(2'd1, 6'h08, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'd0);
        in_valid = 1'b1; cyc();
        set_fields(2'd2, 6'd2, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
        cyc(); in_valid = 1'b0;
        chk("t2_data0", wr_data, 32'h2022_0005);
        chk("t2_addr0", 32'(wr_addr), 32'h10);
        cyc();
        chk("t2_data1", wr_data, 32'h0800_0010);
        chk("t2_addr1", 32'(wr_addr), 32'h11);
        cyc(); cyc();

        // Back-pressure: two accepted, third stalls
        do_start(8'h20);
        wr_ack = 1'b0; in_valid = 1'b1;
        repeat (3) begin rand_fields(2'd1); cyc(); end
        chk("t3_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        repeat (2) cyc();
        wr_ack = 1'b1;
        repeat (3) cyc();
        chk("t3_ready", 32'(in_ready), 32'd1);
        chk("t3_count", 32'(count), 32'd2);

        // Pointer wrap
        do_start(8'hFF);
        in_valid = 1'b1;
        repeat (2) begin rand_fields(2'd1); cyc(); end
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("t4_wrap", 32'(wrap), 32'd1);
        chk("t4_count", 32'(count), 32'd2);

        // Reserved format
        do_start(8'h00);
        rand_fields(2'd3);
        in_valid = 1'b1; cyc(); in_valid = 1'b0;
        repeat (2) cyc();
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_no_write", 32'(count), 32'd0);
`ifdef ENC_FIELD_CHECK_EN
        do_start(8'h00);
        set_fields(2'd0, 6'h08, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        in_valid = 1'b1; cyc(); in_valid = 1'b0;
        repeat (2) cyc();
        chk("t5_field_err", 32'(err), 32'd1);
        chk("t5_field_no_write", 32'(wr_en), 32'd0);
`endif

        // start during a stalled write
        do_start(8'h30);
        wr_ack = 1'b0;
        rand_fields(2'd1);
        in_valid = 1'b1; cyc(); in_valid = 1'b0;
        cyc();
        chk("t6_busy", 32'(wr_en), 32'd1);
        start = 1'b1; start_addr = 8'h40; wr_ack = 1'b1;
        cyc();
        start = 1'b0; wr_ack = 1'b0;
        chk("t6_abandon", 32'(wr_en), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        rand_fields(2'd2);
        in_valid = 1'b1; cyc(); in_valid = 1'b0;
        cyc();
        chk("t6_new_addr", 32'(wr_addr), 32'h40);
        wr_ack = 1'b1; cyc();

        // Count saturation
        do_start(8'h00);
        wr_ack = 1'b1; in_valid = 1'b1;
        repeat (270) begin rand_fields(2'd1); cyc(); end
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("sat_count", 32'(count), 32'd256);
        chk("sat_wrap", 32'(wrap), 32'd1);

        // Randomized traffic
        repeat (3000) begin
            start = ($urandom_range(0, 49) == 0);
            start_addr = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
            in_valid = ($urandom_range(0, 2) != 0);
            wr_ack = 1'($urandom_range(0, 1));
            rand_fields(2'($urandom_range(0, 3)));
            cyc();
        end
        start = 1'b0;

        // Asynchronous reset in the middle of a write
        do_start(8'h50);
        wr_ack = 1'b0;
        rand_fields(2'd1);
        in_valid = 1'b1; cyc(); in_valid = 1'b0;
        cyc();
        chk("rst_mid_busy", 32'(wr_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd0);
        mq.delete(); mptr = '0; merr = 1'b0; mwrap = 1'b0; mwen = 1'b0; mcount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        wr_ack = 1'b1;
        rand_fields(2'd1);
        in_valid = 1'b1; cyc(); in_valid = 1'b0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
